len5_mmio_monitor: RTL and testbench
====================================

# len5_mmio_monitor

Parametrised simulation MMIO monitor for LEN5 bare-metal benches: snoops the datapath instruction, load and store request handshakes and provides multi-channel serial line capture, a timed exit register, and handshake statistics. It sits alongside the memory emulator on the datapath memory ports, is purely passive, and never drives bus signals. It generalises single-channel serial/exit sniffing with N channels, bounded line buffers, a registered line-output handshake, first-write-wins exit, and counter freezing.

## Interface
- XLEN, 64, address/data width
- NUM_CH, 2, serial channels (1..8)
- SERIAL_BASE, 64'h2000_0000, channel 0 serial register address
- CH_STRIDE, 64'h10, address step between channels
- EXIT_ADDR, 64'h2000_0100, exit register address
- LINE_DEPTH, 64, bytes per line buffer (power of 2, ≥2)
- EXIT_TIMEOUT, 50, cycles from exit capture to exit_o
- CNT_W, 64, statistics counter width
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- instr_req_i / instr_gnt_i  in  1 each  instruction request handshake
- load_req_i / load_gnt_i  in  1 each  load request handshake
- store_req_i / store_gnt_i  in  1 each  store request handshake
- store_addr_i  in  XLEN  store address
- store_be_i  in  8  store byte enables
- store_wdata_i  in  XLEN  store data
- line_valid_o  out  1  completed line available
- line_ready_i  in  1  consumer accepts line
- line_ch_o  out  $clog2(NUM_CH) (min 1)  source channel
- line_len_o  out  $clog2(LINE_DEPTH)+1  byte count
- line_data_o  out  LINE_DEPTH*8  bytes, byte 0 = first char in bits [7:0], unused bytes zero
- dropped_o  out  16  saturating count of dropped chars
- exit_o  out  1  sticky exit flag
- exit_code_o  out  8  captured exit code
- exit_success_o  out  1  exit_o && exit_code_o==0
- num_instr_o / num_load_o / num_store_o  out  CNT_W each  accepted handshakes

## Operation
- Accepted store: store_req_i && store_gnt_i. All address matches compare full XLEN and require store_be_i[0]; char/code = store_wdata_i[7:0].
- Channel c matches SERIAL_BASE + c*CH_STRIDE. Per-channel FSM FILL/HELD, count register, LINE_DEPTH-byte buffer.
  - FILL, terminator (8'h00, "\n", "\r"), count>0 → HELD; terminator not stored. Terminator with count==0 ignored.
  - FILL, other char → stored at buffer[count], count++; if count reaches LINE_DEPTH → HELD (line truncated, next char starts new line).
  - HELD, any char → dropped, dropped_o++ (saturates at 16'hFFFF).
- Output slot (registered): when empty, or emptied this cycle by line_valid_o && line_ready_i, loads from the lowest-index HELD channel, copying buffer/count/index; that channel returns to FILL with count 0 the same edge. Slot contents stable while line_valid_o && !line_ready_i.
- Exit: accepted store to EXIT_ADDR while idle → exit_code_o captured, counters freeze, down-counter loaded with EXIT_TIMEOUT. Later exit writes ignored (first wins). On counter==0: exit_o=1, held until reset.
- Statistics: each counter increments on its req&&gnt, wraps modulo 2^CNT_W, frozen from the exit capture edge (capturing store itself counted).

## Timing
- Reset: all outputs 0; all channels FILL, count 0; slot empty; exit idle.
- Char accepted cycle t → buffer/FSM updated edge end of t; line in slot edge end of t+1; line_valid_o high in t+2.
- Line accepted cycle t → line_valid_o low in t+1 unless another HELD channel reloads (back-to-back lines, no bubble).
- Channel freed by slot load may accept a new char in the same cycle as the load (char written at index 0).
- Exit store cycle t → exit_o high in cycle t+EXIT_TIMEOUT+1; EXIT_TIMEOUT=0 → t+1.
- Serial and exit cannot coincide (single store port). Reset mid-line or mid-countdown discards all state.

## Test plan
- Ch0 writes "H","i","\n" at t..t+2 → line_valid_o at t+4, line_ch_o=0, line_len_o=2, line_data_o[15:0]=16'h6948.
- Ch1 line ready while slot holds ch0 line with line_ready_i=0 for 5 cycles → slot stable; accept → ch1 line (len per writes) valid next cycle.
- 64 non-terminator chars to ch0, no reads → line_len_o=64, extra chars on ch0 increment dropped_o by 1 each.
- Lone "\n" / 8'h00 on ch0 with count 0 → no line; store with be[0]=0 to SERIAL_BASE → ignored.
- Exit store 8'h00 at t, second exit 8'h05 at t+3 → exit_o at t+51, exit_code_o=0, exit_success_o=1; counters unchanged after t.
- Assert rst_ni low mid-countdown and mid-line → all outputs 0 asynchronously, no exit after release.

Source files
------------

// File: rtl/len5_mmio_monitor.sv
// Passive MMIO monitor for LEN5 bare-metal benches: snoops the datapath request
// handshakes for multi-channel serial line capture, a timed exit register and statistics.
module len5_mmio_monitor #(
  parameter int unsigned     XLEN         = 64,
  parameter int unsigned     NUM_CH       = 2,
  parameter logic [XLEN-1:0] SERIAL_BASE  = 64'h2000_0000,
  parameter logic [XLEN-1:0] CH_STRIDE    = 64'h10,
  parameter logic [XLEN-1:0] EXIT_ADDR    = 64'h2000_0100,
  parameter int unsigned     LINE_DEPTH   = 64,
  parameter int unsigned     EXIT_TIMEOUT = 50,
  parameter int unsigned     CNT_W        = 64,
  localparam int unsigned    CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned    LEN_W        = $clog2(LINE_DEPTH) + 1,
  localparam int unsigned    TMR_W        = (EXIT_TIMEOUT > 0) ? $clog2(EXIT_TIMEOUT + 1) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  input  logic                    instr_gnt_i,
  input  logic                    load_req_i,
  input  logic                    load_gnt_i,
  input  logic                    store_req_i,
  input  logic                    store_gnt_i,
  input  logic [XLEN-1:0]         store_addr_i,
  input  logic [7:0]              store_be_i,
  input  logic [XLEN-1:0]         store_wdata_i,
  output logic                    line_valid_o,
  input  logic                    line_ready_i,
  output logic [CH_W-1:0]         line_ch_o,
  output logic [LEN_W-1:0]        line_len_o,
  output logic [LINE_DEPTH*8-1:0] line_data_o,
  output logic [15:0]             dropped_o,
  output logic                    exit_o,
  output logic [7:0]              exit_code_o,
  output logic                    exit_success_o,
  output logic [CNT_W-1:0]        num_instr_o,
  output logic [CNT_W-1:0]        num_load_o,
  output logic [CNT_W-1:0]        num_store_o
);

  typedef enum logic {CH_FILL, CH_HELD} ch_state_e;
  typedef enum logic [1:0] {EX_IDLE, EX_WAIT, EX_DONE} ex_state_e;

  ch_state_e                  ch_state_q [NUM_CH];
  ch_state_e                  ch_state_d [NUM_CH];
  logic [LEN_W-1:0]           ch_cnt_q   [NUM_CH];
  logic [LEN_W-1:0]           ch_cnt_d   [NUM_CH];
  logic [LINE_DEPTH-1:0][7:0] ch_buf_q   [NUM_CH];
  logic [LINE_DEPTH-1:0][7:0] ch_buf_d   [NUM_CH];

  logic [15:0]                dropped_q, dropped_d;
  logic                       slot_valid_q;
  logic [CH_W-1:0]            slot_ch_q;
  logic [LEN_W-1:0]           slot_len_q;
  logic [LINE_DEPTH-1:0][7:0] slot_data_q;

  ex_state_e                  ex_state_q, ex_state_d;
  logic [TMR_W-1:0]           tmr_q, tmr_d;
  logic [7:0]                 exit_code_q, exit_code_d;
  logic [CNT_W-1:0]           num_instr_q, num_load_q, num_store_q;

  logic              st_acc, exit_wr, is_term, sel_valid, slot_load;
  logic [7:0]        wchar;
  logic [CH_W-1:0]   sel_ch;
  logic [NUM_CH-1:0] ch_hit, ch_held, ch_free;
  logic              unused_bits;

  assign unused_bits = ^{store_be_i[7:1], store_wdata_i[XLEN-1:8]};

  // Only byte lane 0 carries characters and exit codes.
  assign st_acc  = store_req_i && store_gnt_i && store_be_i[0];
  assign wchar   = store_wdata_i[7:0];
  assign is_term = (wchar == 8'h00) || (wchar == 8'h0A) || (wchar == 8'h0D);
  assign exit_wr = st_acc && (store_addr_i == EXIT_ADDR);

  always_comb begin
    ch_hit  = '0;
    ch_held = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_hit[c]  = st_acc && (store_addr_i == SERIAL_BASE + XLEN'(c) * CH_STRIDE);
      ch_held[c] = (ch_state_q[c] == CH_HELD);
    end
  end

  // Lowest-index held channel wins the output slot.
  always_comb begin
    sel_valid = 1'b0;
    sel_ch    = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (ch_held[c]) begin
        sel_valid = 1'b1;
        sel_ch    = CH_W'(c);
      end
    end
  end

  assign slot_load = (!slot_valid_q || line_ready_i) && sel_valid;

  always_comb begin
    ch_free = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_free[c] = slot_load && (sel_ch == CH_W'(c));
    end
  end

  // A channel drained into the slot this edge is treated as empty, so a char
  // arriving in the same cycle lands at index 0 instead of being dropped.
  always_comb begin
    dropped_d = dropped_q;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_state_d[c] = ch_state_q[c];
      ch_cnt_d[c]   = ch_cnt_q[c];
      ch_buf_d[c]   = ch_buf_q[c];
      if (ch_free[c]) begin
        ch_state_d[c] = CH_FILL;
        ch_cnt_d[c]   = '0;
        ch_buf_d[c]   = '0;
      end
      if (ch_hit[c]) begin
        if (ch_state_d[c] == CH_FILL) begin
          if (is_term) begin
            if (ch_cnt_d[c] != '0) ch_state_d[c] = CH_HELD;
          end else begin
            ch_buf_d[c][ch_cnt_d[c][LEN_W-2:0]] = wchar;
            ch_cnt_d[c] = ch_cnt_d[c] + LEN_W'(1);
            if (ch_cnt_d[c] == LEN_W'(LINE_DEPTH)) ch_state_d[c] = CH_HELD;
          end
        end else if (dropped_d != 16'hFFFF) begin
          dropped_d = dropped_d + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_state_q[c] <= CH_FILL;
        ch_cnt_q[c]   <= '0;
        ch_buf_q[c]   <= '0;
      end
      dropped_q    <= '0;
      slot_valid_q <= 1'b0;
      slot_ch_q    <= '0;
      slot_len_q   <= '0;
      slot_data_q  <= '0;
    end else begin
      ch_state_q <= ch_state_d;
      ch_cnt_q   <= ch_cnt_d;
      ch_buf_q   <= ch_buf_d;
      dropped_q  <= dropped_d;
      if (slot_load) begin
        slot_valid_q <= 1'b1;
        slot_ch_q    <= sel_ch;
        slot_len_q   <= ch_cnt_q[sel_ch];
        slot_data_q  <= ch_buf_q[sel_ch];
      end else if (line_ready_i) begin
        slot_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    ex_state_d  = ex_state_q;
    tmr_d       = tmr_q;
    exit_code_d = exit_code_q;
    case (ex_state_q)
      EX_IDLE: begin
        if (exit_wr) begin
          ex_state_d  = EX_WAIT;
          tmr_d       = TMR_W'(EXIT_TIMEOUT);
          exit_code_d = wchar;
        end
      end
      EX_WAIT: begin
        if (tmr_q == '0) ex_state_d = EX_DONE;
        else             tmr_d = tmr_q - TMR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_state_q  <= EX_IDLE;
      tmr_q       <= '0;
      exit_code_q <= '0;
    end else begin
      ex_state_q  <= ex_state_d;
      tmr_q       <= tmr_d;
      exit_code_q <= exit_code_d;
    end
  end

  // Counters stop once an exit has been captured; the capturing store still counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_instr_q <= '0;
      num_load_q  <= '0;
      num_store_q <= '0;
    end else if (ex_state_q == EX_IDLE) begin
      if (instr_req_i && instr_gnt_i) num_instr_q <= num_instr_q + CNT_W'(1);
      if (load_req_i && load_gnt_i)   num_load_q  <= num_load_q + CNT_W'(1);
      if (store_req_i && store_gnt_i) num_store_q <= num_store_q + CNT_W'(1);
    end
  end

  assign line_valid_o   = slot_valid_q;
  assign line_ch_o      = slot_ch_q;
  assign line_len_o     = slot_len_q;
  assign line_data_o    = slot_data_q;
  assign dropped_o      = dropped_q;
  assign exit_o         = (ex_state_q == EX_DONE) || ((ex_state_q == EX_WAIT) && (tmr_q == '0));
  assign exit_code_o    = exit_code_q;
  assign exit_success_o = exit_o && (exit_code_q == 8'h00);
  assign num_instr_o    = num_instr_q;
  assign num_load_o     = num_load_q;
  assign num_store_o    = num_store_q;

endmodule

// File: tb/tb_len5_mmio_monitor.sv
// Directed self-checking bench for len5_mmio_monitor: line capture, slot handshake,
// truncation/drop, ignored writes, exit timing, statistics freeze and async reset.
module tb_len5_mmio_monitor;
  localparam int LD = 64;
  localparam logic [63:0] SB  = 64'h2000_0000;
  localparam logic [63:0] SB1 = 64'h2000_0010;
  localparam logic [63:0] EA  = 64'h2000_0100;

  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          instr_req_i = 0, instr_gnt_i = 0, load_req_i = 0, load_gnt_i = 0;
  logic          store_req_i = 0, store_gnt_i = 0;
  logic [63:0]   store_addr_i = '0, store_wdata_i = '0;
  logic [7:0]    store_be_i = '0;
  logic          line_valid_o, line_ready_i = 0;
  logic [0:0]    line_ch_o;
  logic [6:0]    line_len_o;
  logic [LD*8-1:0] line_data_o, exp_data;
  logic [15:0]   dropped_o;
  logic          exit_o, exit_success_o;
  logic [7:0]    exit_code_o;
  logic [63:0]   num_instr_o, num_load_o, num_store_o;
  int            n_pass = 0, n_total = 0;

  len5_mmio_monitor dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_i(instr_gnt_i),
    .load_req_i(load_req_i), .load_gnt_i(load_gnt_i),
    .store_req_i(store_req_i), .store_gnt_i(store_gnt_i),
    .store_addr_i(store_addr_i), .store_be_i(store_be_i), .store_wdata_i(store_wdata_i),
    .line_valid_o(line_valid_o), .line_ready_i(line_ready_i), .line_ch_o(line_ch_o),
    .line_len_o(line_len_o), .line_data_o(line_data_o), .dropped_o(dropped_o),
    .exit_o(exit_o), .exit_code_o(exit_code_o), .exit_success_o(exit_success_o),
    .num_instr_o(num_instr_o), .num_load_o(num_load_o), .num_store_o(num_store_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1);
  end

  // Inputs change on the falling edge; outputs are read right after, mid-cycle.
  task automatic drive(input logic ir, ig, lr, lg, sr, sg,
                       input logic [63:0] a, input logic [7:0] d, input logic [7:0] be);
    @(negedge clk_i);
    instr_req_i = ir; instr_gnt_i = ig; load_req_i = lr; load_gnt_i = lg;
    store_req_i = sr; store_gnt_i = sg; store_addr_i = a; store_be_i = be;
    store_wdata_i = {56'hA5A5_A5A5_A5A5_A5, d};
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    drive(0, 0, 0, 0, 1, 1, a, d, 8'hFF);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, '0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if (line_valid_o !== 0 || line_ch_o !== 0 || line_len_o !== 0 || line_data_o !== '0 ||
        dropped_o !== 0 || exit_o !== 0 || exit_code_o !== 0 || exit_success_o !== 0 ||
        num_instr_o !== 0 || num_load_o !== 0 || num_store_o !== 0)
      $display("FAIL reset_outputs valid=%0b len=%0d drop=%0d exit=%0b code=%0h cnt=%0d/%0d/%0d exp all 0",
               line_valid_o, line_len_o, dropped_o, exit_o, exit_code_o, num_instr_o, num_load_o, num_store_o);
    else n_pass++;
    nop(); rst_ni = 1'b1;
    nop(); nop();
    n_total++;
    if (line_valid_o !== 0 || exit_o !== 0 || num_store_o !== 0)
      $display("FAIL idle_after_reset valid=%0b exit=%0b stores=%0d exp 0/0/0", line_valid_o, exit_o, num_store_o);
    else n_pass++;
  endtask

  task automatic test_basic_line();
    wr(SB, 8'h48); wr(SB, 8'h69); wr(SB, 8'h0A);
    nop();
    n_total++;
    if (line_valid_o !== 1'b0) $display("FAIL basic_early valid=%0b exp=0", line_valid_o);
    else n_pass++;
    nop();
    exp_data = '0; exp_data[15:0] = 16'h6948;
    n_total++;
    if (line_valid_o !== 1 || line_ch_o !== 0 || line_len_o !== 7'd2 || line_data_o !== exp_data)
      $display("FAIL basic_line valid=%0b ch=%0d len=%0d data=%h exp 1/0/2/6948",
               line_valid_o, line_ch_o, line_len_o, line_data_o[63:0]);
    else n_pass++;
    line_ready_i = 1'b1;
    nop(); line_ready_i = 1'b0;
    n_total++;
    if (line_valid_o !== 1'b0) $display("FAIL basic_drain valid=%0b exp=0", line_valid_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    wr(SB, 8'h41); wr(SB, 8'h42); wr(SB, 8'h0A);
    wr(SB1, 8'h78); wr(SB1, 8'h79); wr(SB1, 8'h7A); wr(SB1, 8'h0D);
    exp_data = '0; exp_data[15:0] = 16'h4241;
    for (int k = 0; k < 5; k++) begin
      nop();
      n_total++;
      if (line_valid_o !== 1 || line_ch_o !== 0 || line_len_o !== 7'd2 || line_data_o !== exp_data)
        $display("FAIL hold_stable cyc=%0d valid=%0b ch=%0d len=%0d data=%h exp 1/0/2/4241",
                 k, line_valid_o, line_ch_o, line_len_o, line_data_o[63:0]);
      else n_pass++;
    end
    nop(); line_ready_i = 1'b1;
    nop();
    exp_data = '0; exp_data[23:0] = 24'h7A7978;
    n_total++;
    if (line_valid_o !== 1 || line_ch_o !== 1 || line_len_o !== 7'd3 || line_data_o !== exp_data)
      $display("FAIL b2b_ch1 valid=%0b ch=%0d len=%0d data=%h exp 1/1/3/7a7978",
               line_valid_o, line_ch_o, line_len_o, line_data_o[63:0]);
    else n_pass++;
    nop(); line_ready_i = 1'b0;
    n_total++;
    if (line_valid_o !== 1'b0) $display("FAIL b2b_drain valid=%0b exp=0", line_valid_o);
    else n_pass++;
  endtask

  task automatic test_truncate_drop();
    for (int i = 0; i < 64; i++) wr(SB, 8'(8'h21 + i));
    nop(); nop();
    for (int i = 0; i < 64; i++) exp_data[i*8 +: 8] = 8'(8'h21 + i);
    n_total++;
    if (line_valid_o !== 1 || line_ch_o !== 0 || line_len_o !== 7'd64 || line_data_o !== exp_data)
      $display("FAIL trunc_line valid=%0b ch=%0d len=%0d lo=%h exp 1/0/64/%h",
               line_valid_o, line_ch_o, line_len_o, line_data_o[63:0], exp_data[63:0]);
    else n_pass++;
    for (int i = 0; i < 64; i++) wr(SB, 8'(8'h41 + i));
    for (int i = 0; i < 3; i++) wr(SB, 8'h7E);
    nop();
    n_total++;
    if (dropped_o !== 16'd3) $display("FAIL dropped_count got=%0d exp=3", dropped_o);
    else n_pass++;
    n_total++;
    if (line_valid_o !== 1 || line_len_o !== 7'd64 || line_data_o[7:0] !== 8'h21)
      $display("FAIL trunc_hold valid=%0b len=%0d b0=%h exp 1/64/21", line_valid_o, line_len_o, line_data_o[7:0]);
    else n_pass++;
    wr(SB, 8'h51); line_ready_i = 1'b1;
    wr(SB, 8'h0A); line_ready_i = 1'b0;
    n_total++;
    if (line_valid_o !== 1 || line_len_o !== 7'd64 || line_data_o[7:0] !== 8'h41 ||
        line_data_o[511:504] !== 8'h80 || dropped_o !== 16'd3)
      $display("FAIL second_line valid=%0b len=%0d b0=%h b63=%h drop=%0d exp 1/64/41/80/3",
               line_valid_o, line_len_o, line_data_o[7:0], line_data_o[511:504], dropped_o);
    else n_pass++;
    nop(); line_ready_i = 1'b1;
    nop(); line_ready_i = 1'b0;
    exp_data = '0; exp_data[7:0] = 8'h51;
    n_total++;
    if (line_valid_o !== 1 || line_len_o !== 7'd1 || line_data_o !== exp_data)
      $display("FAIL reload_same_cycle valid=%0b len=%0d data=%h exp 1/1/51",
               line_valid_o, line_len_o, line_data_o[63:0]);
    else n_pass++;
    line_ready_i = 1'b1;
    nop(); line_ready_i = 1'b0;
    n_total++;
    if (line_valid_o !== 1'b0) $display("FAIL trunc_drain valid=%0b exp=0", line_valid_o);
    else n_pass++;
  endtask

  task automatic test_ignored();
    wr(SB, 8'h0A); wr(SB, 8'h00); wr(SB, 8'h0D);
    drive(0, 0, 0, 0, 1, 1, SB, 8'h41, 8'hFE);
    drive(0, 0, 0, 0, 1, 0, SB, 8'h43, 8'hFF);
    wr(SB + 64'h8, 8'h44);
    nop(); nop(); nop();
    n_total++;
    if (line_valid_o !== 1'b0) $display("FAIL empty_term valid=%0b len=%0d exp 0", line_valid_o, line_len_o);
    else n_pass++;
    wr(SB, 8'h42); wr(SB, 8'h0A);
    nop(); nop();
    exp_data = '0; exp_data[7:0] = 8'h42;
    n_total++;
    if (line_valid_o !== 1 || line_len_o !== 7'd1 || line_data_o !== exp_data || dropped_o !== 16'd3)
      $display("FAIL ignored_writes valid=%0b len=%0d data=%h drop=%0d exp 1/1/42/3",
               line_valid_o, line_len_o, line_data_o[63:0], dropped_o);
    else n_pass++;
    line_ready_i = 1'b1;
    nop(); line_ready_i = 1'b0;
  endtask

  task automatic test_exit_stats();
    nop(); rst_ni = 1'b0;
    nop(); rst_ni = 1'b1;
    drive(1, 1, 1, 1, 0, 0, '0, 8'h00, 8'h00);
    drive(1, 1, 0, 0, 0, 0, '0, 8'h00, 8'h00);
    drive(1, 0, 1, 0, 1, 0, EA, 8'h09, 8'hFF);
    drive(0, 0, 1, 1, 0, 0, '0, 8'h00, 8'h00);
    wr(SB, 8'h61);
    drive(1, 1, 0, 0, 1, 1, EA, 8'h00, 8'hFF);
    drive(1, 1, 1, 1, 1, 1, SB, 8'h62, 8'hFF);
    nop();
    n_total++;
    if (num_instr_o !== 64'd3 || num_load_o !== 64'd2 || num_store_o !== 64'd2 || exit_code_o !== 8'h00 || exit_o !== 0)
      $display("FAIL stats_capture cnt=%0d/%0d/%0d code=%0h exit=%0b exp 3/2/2/0/0",
               num_instr_o, num_load_o, num_store_o, exit_code_o, exit_o);
    else n_pass++;
    wr(EA, 8'h05);
    for (int k = 4; k <= 50; k++) drive(1, 1, 1, 1, 0, 0, '0, 8'h00, 8'h00);
    n_total++;
    if (exit_o !== 1'b0) $display("FAIL exit_early at t+50 got=%0b exp=0", exit_o);
    else n_pass++;
    nop();
    n_total++;
    if (exit_o !== 1 || exit_code_o !== 8'h00 || exit_success_o !== 1)
      $display("FAIL exit_fire exit=%0b code=%0h succ=%0b exp 1/00/1", exit_o, exit_code_o, exit_success_o);
    else n_pass++;
    n_total++;
    if (num_instr_o !== 64'd3 || num_load_o !== 64'd2 || num_store_o !== 64'd2)
      $display("FAIL stats_frozen cnt=%0d/%0d/%0d exp 3/2/2", num_instr_o, num_load_o, num_store_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    nop(); rst_ni = 1'b0;
    nop(); rst_ni = 1'b1;
    wr(SB, 8'h61); wr(SB, 8'h62); wr(EA, 8'h07);
    nop();
    n_total++;
    if (exit_code_o !== 8'h07 || exit_o !== 0 || num_store_o !== 64'd3)
      $display("FAIL mid_capture code=%0h exit=%0b stores=%0d exp 07/0/3", exit_code_o, exit_o, num_store_o);
    else n_pass++;
    for (int k = 0; k < 5; k++) nop();
    #2 rst_ni = 1'b0;
    #1;
    n_total++;
    if (line_valid_o !== 0 || line_len_o !== 0 || line_data_o !== '0 || dropped_o !== 0 || exit_o !== 0 ||
        exit_code_o !== 0 || exit_success_o !== 0 || num_instr_o !== 0 || num_load_o !== 0 || num_store_o !== 0)
      $display("FAIL async_reset valid=%0b code=%0h exit=%0b stores=%0d exp all 0",
               line_valid_o, exit_code_o, exit_o, num_store_o);
    else n_pass++;
    nop(); nop(); rst_ni = 1'b1;
    for (int k = 0; k < 60; k++) nop();
    n_total++;
    if (exit_o !== 0 || line_valid_o !== 0)
      $display("FAIL post_reset_idle exit=%0b valid=%0b exp 0/0", exit_o, line_valid_o);
    else n_pass++;
    wr(SB, 8'h63); wr(SB, 8'h0A);
    nop(); nop();
    exp_data = '0; exp_data[7:0] = 8'h63;
    n_total++;
    if (line_valid_o !== 1 || line_len_o !== 7'd1 || line_data_o !== exp_data)
      $display("FAIL post_reset_line valid=%0b len=%0d data=%h exp 1/1/63", line_valid_o, line_len_o, line_data_o[63:0]);
    else n_pass++;
    line_ready_i = 1'b1;
    nop(); line_ready_i = 1'b0;
    wr(EA, 8'h07);
    for (int k = 1; k <= 51; k++) nop();
    n_total++;
    if (exit_o !== 1 || exit_code_o !== 8'h07 || exit_success_o !== 0)
      $display("FAIL exit_nonzero exit=%0b code=%0h succ=%0b exp 1/07/0", exit_o, exit_code_o, exit_success_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_back_to_back();
    test_truncate_drop();
    test_ignored();
    test_exit_stats();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
